// File: rtl/psram_pkg.sv
// Shared types and default sizing for the PSRAM receive/transmit buffers.
package psram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rx_state_e;

    localparam int DEF_DW    = 32;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_LW    = 16;

endpackage

// File: rtl/psram_sync_fifo.sv
// Single-clock FIFO with flush; head word is always visible on rdata.
module psram_sync_fifo #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          hclk,
    input  logic          hrst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge hclk) begin
        if (hrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge hclk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/psram_rx_fifo.sv
// PSRAM receive buffer: DEPTH-entry FIFO with per-transaction word count,
// completion flag and sticky overrun error.
//   state | meaning
//   IDLE  | no transaction; waits for start
//   BUSY  | accepting words until len_q have been pushed
//   DRAIN | all words received; emptying FIFO into RAM
//   DONE  | transaction complete; done held until next start
module psram_rx_fifo
    import psram_pkg::*;
#(
    parameter  int DW    = DEF_DW,
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int LW    = DEF_LW,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          hclk,
    input  logic          hrst,
    input  logic          start,
    input  logic [LW-1:0] xfer_len,
    input  logic          rx_vld,
    output logic          rx_rdy,
    input  logic [DW-1:0] rx_data,
    output logic          ram_wr_req,
    input  logic          ram_wr_ack,
    output logic [DW-1:0] ram_wdata,
    output logic [AW:0]   level,
    output logic          done,
    output logic          err_extra
);

    rx_state_e     state_q, state_d;
    logic [LW-1:0] rx_cnt_q, rx_cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] rx_cnt_inc;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [AW:0]   fifo_count;
    logic          fifo_full, fifo_empty;
    logic          push, pop;

    // Handshakes look only at registered state, so a pop never frees room
    // for a push in the same cycle.
    assign rx_rdy     = (state_q == BUSY) & ~fifo_full;
    assign ram_wr_req = ((state_q == BUSY) | (state_q == DRAIN)) & ~fifo_empty;
    assign push       = rx_vld & rx_rdy & ~start;
    assign pop        = ram_wr_ack & ram_wr_req & ~start;
    assign rx_cnt_inc = rx_cnt_q + 1'b1;
    assign level      = fifo_count;
    assign done       = done_q;
    assign err_extra  = err_q;

    psram_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .hclk  (hclk),
        .hrst  (hrst),
        .flush (start),
        .push  (push),
        .wdata (rx_data),
        .pop   (pop),
        .rdata (ram_wdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        rx_cnt_d = rx_cnt_q;
        len_d    = len_q;
        err_d    = err_q;
        if (start) begin
            rx_cnt_d = '0;
            len_d    = xfer_len;
            err_d    = 1'b0;
            state_d  = (xfer_len != '0) ? BUSY : DONE;
        end else begin
            case (state_q)
                BUSY: begin
                    if (push) begin
                        rx_cnt_d = rx_cnt_inc;
                        if (rx_cnt_inc == len_q) state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (rx_vld) err_d = 1'b1;
                    if ((fifo_count == '0) || ((fifo_count == (AW+1)'(1)) && pop))
                        state_d = DONE;
                end
                DONE: begin
                    if (rx_vld) err_d = 1'b1;
                end
                default: state_d = state_q;
            endcase
        end
        done_d = (state_d == DONE);
    end

    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_q  <= IDLE;
            rx_cnt_q <= '0;
            len_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rx_cnt_q <= rx_cnt_d;
            len_q    <= len_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_psram_rx_fifo.sv
// Self-checking bench for psram_rx_fifo: behavioural model plus a word scoreboard.
module tb_psram_rx_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = 16;
    localparam int AW    = $clog2(DEPTH);

    localparam int S_IDLE  = 0;
    localparam int S_BUSY  = 1;
    localparam int S_DRAIN = 2;
    localparam int S_DONE  = 3;

    logic          hclk = 1'b0;
    logic          hrst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] xfer_len = '0;
    logic          rx_vld = 1'b0;
    logic          rx_rdy;
    logic [DW-1:0] rx_data = '0;
    logic          ram_wr_req;
    logic          ram_wr_ack = 1'b0;
    logic [DW-1:0] ram_wdata;
    logic [AW:0]   level;
    logic          done;
    logic          err_extra;

    psram_rx_fifo #(.DW(DW), .DEPTH(DEPTH), .LW(LW)) dut (
        .hclk       (hclk),
        .hrst       (hrst),
        .start      (start),
        .xfer_len   (xfer_len),
        .rx_vld     (rx_vld),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .ram_wr_req (ram_wr_req),
        .ram_wr_ack (ram_wr_ack),
        .ram_wdata  (ram_wdata),
        .level      (level),
        .done       (done),
        .err_extra  (err_extra)
    );

    always #5 hclk = ~hclk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    int            m_st  = S_IDLE;
    int            m_cnt = 0;
    int            m_len = 0;
    int            m_lvl = 0;
    bit            m_done = 1'b0;
    bit            m_err  = 1'b0;
    logic [DW-1:0] sb [$];

    int d_max  = 0;
    int d_pops = 0;
    int widx   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_rdy();
        return (m_st == S_BUSY) && (m_lvl < DEPTH);
    endfunction

    function automatic bit m_req();
        return ((m_st == S_BUSY) || (m_st == S_DRAIN)) && (m_lvl != 0);
    endfunction

    // Inputs are already set; check outputs, advance model, cross one edge.
    task automatic step();
        bit e_rdy, e_req, mpush, mpop;
        e_rdy = m_rdy();
        e_req = m_req();
        if (!hrst) begin
            chk("rx_rdy",     64'(rx_rdy),     64'(e_rdy));
            chk("ram_wr_req", 64'(ram_wr_req), 64'(e_req));
            chk("level",      64'(level),      64'(m_lvl));
            chk("done",       64'(done),       64'(m_done));
            chk("err_extra",  64'(err_extra),  64'(m_err));
            if (e_req && sb.size() > 0) chk("ram_wdata", 64'(ram_wdata), 64'(sb[0]));
            if (int'(level) > d_max) d_max = int'(level);
            if (ram_wr_req && ram_wr_ack && !start) d_pops++;
        end
        if (hrst) begin
            m_st = S_IDLE; m_cnt = 0; m_len = 0; m_lvl = 0;
            m_done = 1'b0; m_err = 1'b0; sb.delete();
        end else if (start) begin
            sb.delete();
            m_lvl = 0; m_cnt = 0; m_len = int'(xfer_len); m_err = 1'b0;
            m_st = (xfer_len != 0) ? S_BUSY : S_DONE;
            m_done = (m_st == S_DONE);
        end else begin
            mpush = e_rdy && rx_vld;
            mpop  = e_req && ram_wr_ack;
            if ((m_st == S_DRAIN || m_st == S_DONE) && rx_vld) m_err = 1'b1;
            if (mpop) begin void'(sb.pop_front()); m_lvl--; end
            if (mpush) begin sb.push_back(rx_data); m_lvl++; m_cnt++; end
            if (m_st == S_BUSY && mpush && m_cnt == m_len) m_st = S_DRAIN;
            else if (m_st == S_DRAIN && m_lvl == 0) m_st = S_DONE;
            m_done = (m_st == S_DONE);
        end
        @(posedge hclk);
        @(negedge hclk);
    endtask

    task automatic go(input int len);
        start = 1'b1; xfer_len = LW'(len); rx_vld = 1'b0;
        step();
        start = 1'b0;
    endtask

    task automatic idle(input int n, input bit ack);
        rx_vld = 1'b0; ram_wr_ack = ack;
        for (int i = 0; i < n; i++) step();
    endtask

    // Offer words base+widx .. base+hi-1, advancing on each accepted word.
    task automatic feed(input int hi, input logic [DW-1:0] base, input bit ack, input int budget);
        for (int c = 0; c < budget && widx < hi; c++) begin
            rx_vld = 1'b1; rx_data = base + DW'(widx); ram_wr_ack = ack;
            if (m_rdy()) widx++;
            step();
        end
        rx_vld = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        rx_vld = 1'b0; ram_wr_ack = 1'b1;
        for (int c = 0; c < budget && !m_done; c++) step();
        chk(tag, 64'(done), 64'(1));
    endtask

    initial begin
        @(negedge hclk);
        hrst = 1'b1;
        idle(3, 1'b0);
        hrst = 1'b0;
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_rdy",   64'(rx_rdy), 64'(0));
        chk("rst_req",   64'(ram_wr_req), 64'(0));
        idle(2, 1'b1);

        // basic
        go(3); widx = 0;
        feed(3, 32'hA0, 1'b1, 10);
        wait_done("basic_done", 10);
        chk("basic_err", 64'(err_extra), 64'(0));
        idle(2, 1'b1);

        // backpressure and full
        go(6); widx = 0; d_max = 0;
        feed(6, 32'h0, 1'b0, 7);
        chk("bp_level", 64'(level), 64'(4));
        chk("bp_rdy_full", 64'(rx_rdy), 64'(0));
        chk("bp_accepted", 64'(widx), 64'(4));
        feed(6, 32'h0, 1'b1, 10);
        wait_done("bp_done", 10);
        chk("bp_max_level", 64'(d_max), 64'(4));

        // zero length
        go(0);
        chk("zero_done", 64'(done), 64'(1));
        idle(3, 1'b1);

        // extra data
        go(2); widx = 0; d_pops = 0;
        feed(2, 32'hE0, 1'b1, 6);
        rx_vld = 1'b1; rx_data = 32'hBAD; ram_wr_ack = 1'b1;
        step();
        rx_vld = 1'b0;
        wait_done("extra_done", 10);
        chk("extra_err", 64'(err_extra), 64'(1));
        idle(3, 1'b1);
        chk("extra_err_sticky", 64'(err_extra), 64'(1));
        chk("extra_pops", 64'(d_pops), 64'(2));
        go(1);
        chk("extra_clr_err",  64'(err_extra), 64'(0));
        chk("extra_clr_done", 64'(done), 64'(0));
        widx = 0;
        feed(1, 32'hE8, 1'b1, 4);
        wait_done("extra2_done", 6);

        // restart mid-transfer
        go(5); widx = 0;
        feed(2, 32'h50, 1'b0, 4);
        chk("rs_level_pre", 64'(level), 64'(2));
        go(1);
        chk("rs_level", 64'(level), 64'(0));
        widx = 0;
        feed(1, 32'hC0, 1'b1, 4);
        wait_done("rs_done", 6);

        // reset during drain
        go(4); widx = 0;
        feed(4, 32'h70, 1'b0, 6);
        idle(2, 1'b1);
        chk("rm_level_pre", 64'(level), 64'(2));
        hrst = 1'b1;
        idle(1, 1'b0);
        hrst = 1'b0;
        chk("rm_level", 64'(level), 64'(0));
        chk("rm_req",   64'(ram_wr_req), 64'(0));
        chk("rm_rdy",   64'(rx_rdy), 64'(0));
        chk("rm_done",  64'(done), 64'(0));
        rx_vld = 1'b1; rx_data = 32'h99; ram_wr_ack = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rx_vld = 1'b0;
        chk("rm_idle_level", 64'(level), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/psram_rx_fifo.md
Name: psram_rx_fifo

Overview:
- Parametrised single-clock successor to the one-word PSRAM receive buffer.
- Sits in the hclk domain between the PSRAM read datapath, which is already synchronised upstream, and the RAM write port.
- Replaces the single-entry toggle handshake with a DEPTH-entry FIFO and a per-transaction word counter.
- Flags completion and protocol errors, so the controller no longer infers end-of-transfer.

Parameters:
- DW, 32: data word width in bits.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- LW, 16: width of the transfer-length field.
- AW, log2(DEPTH): localparam, pointer width.

Ports:
- hclk  in  1  clock; all logic on the rising edge.
- hrst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse: flush the FIFO, load xfer_len, begin a transaction.
- xfer_len  in  LW  words expected this transaction; sampled only when start=1.
- rx_vld  in  1  rx_data valid.
- rx_rdy  out  1  block can accept a word; a transfer occurs when rx_vld & rx_rdy.
- rx_data  in  DW  received word.
- ram_wr_req  out  1  head word is available for RAM write.
- ram_wr_ack  in  1  RAM consumed the head word; a pop occurs when ram_wr_req & ram_wr_ack.
- ram_wdata  out  DW  head-of-FIFO word; stable while ram_wr_req=1 and no ack.
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- done  out  1  transaction complete; level signal held until next start or reset.
- err_extra  out  1  sticky: rx_vld seen after xfer_len words were accepted.

Behaviour:
- Reset (hrst=1 at edge):
  - state=IDLE; FIFO pointers and count=0; rx_cnt=0.
  - rx_rdy=0, ram_wr_req=0, level=0, done=0, err_extra=0.
  - ram_wdata is don't-care; storage is not reset.
- FSM states: IDLE, BUSY, DRAIN, DONE.
- start=1 overrides everything in any state (has priority over push, pop and hrst-free logic):
  - flush FIFO; rx_cnt=0; len_q=xfer_len; done=0; err_extra=0.
  - next state = BUSY if xfer_len != 0, else DONE (done=1 the following cycle).
  - Any rx handshake or ack in the start cycle is ignored.
- IDLE: rx_rdy=0, ram_wr_req=0; leaves only on start.
- BUSY:
  - rx_rdy = (count < DEPTH). Registered count only: no push while full, even if a pop occurs the same cycle.
  - Each push increments rx_cnt.
  - When a push makes rx_cnt == len_q, go to DRAIN next cycle; rx_rdy drops in that same next cycle.
- DRAIN: rx_rdy=0; when count reaches 0 (after the final pop), go to DONE.
- DONE: done=1, rx_rdy=0, ram_wr_req=0; leaves only on start.
- Output side, in BUSY or DRAIN:
  - ram_wr_req = (count != 0), derived from registered count.
  - ram_wdata = mem[rd_ptr].
- Latency:
  - Word pushed into an empty FIFO at edge N: ram_wr_req=1 with that word from cycle N+1.
  - Pop at edge M: next entry is presented from M+1, or req=0 if the FIFO is now empty.
- ram_wr_ack while ram_wr_req=0: ignored; no pop, no pointer change.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count is AW+1 bits, saturating by construction at 0..DEPTH.
- err_extra: set when rx_vld=1 in DRAIN or DONE. The word is dropped, not stored. Cleared only by start or hrst.
- rx_cnt width: LW bits. A len_q of 2^LW-1 is legal.
- Reset asserted mid-transaction: all state is lost and the block returns to IDLE. No partial completion is signalled.

Decomposition:
- Shared package psram_pkg:
  - FSM state enum (IDLE/BUSY/DRAIN/DONE).
  - Default DW/DEPTH/LW constants.
- One natural sub-module: psram_sync_fifo.
  - Params DW, DEPTH; ports hclk, hrst, flush, push, wdata, pop, rdata, count, full, empty.
  - Reusable by the future tx-side buffer.
- The top level holds the FSM, rx_cnt/len_q and the flags.

Test Plan:
- Basic: xfer_len=3, words 0xA0,0xA1,0xA2, ack held high -> ram_wdata sequence A0,A1,A2, each req one cycle after push; done=1 after third pop; err_extra=0.
- Backpressure/full: DEPTH=4, xfer_len=6, ack=0 -> rx_rdy=0 when level=4, nothing lost. Then ack one per cycle -> words 0..5 in order, done=1, max level=4.
- Zero length: start with xfer_len=0 -> done=1 next cycle, rx_rdy and ram_wr_req never 1.
- Extra data: xfer_len=2, drive 3 words -> third dropped, err_extra=1 sticky; exactly 2 pops; next start clears err_extra and done.
- Restart mid-transfer: xfer_len=5, push 2 words, assert start with xfer_len=1 -> level=0 next cycle, old words never appear; one new word completes the transfer.
- Reset mid-transfer: hrst=1 during DRAIN with level=2 -> next cycle level=0, req=0, rx_rdy=0, done=0; stays in IDLE until start.
